// File: rtl/motion_bus_master_if.sv
// rtl/motion_bus_master_if.sv - strobe/address/data bus between the sequencer and the motion peripheral
interface motion_bus_master_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [3:0]  addr;
  logic [15:0] d_out;
  logic [15:0] d_in;

  modport master (
    output cs,
    output rd,
    output wr,
    output addr,
    output d_out,
    input  d_in
  );

  modport slave (
    input  cs,
    input  rd,
    input  wr,
    input  addr,
    input  d_out,
    output d_in
  );
endinterface

// File: rtl/motion_bus_master.sv
// rtl/motion_bus_master.sv - seven-access update sequencer for the motion peripheral; optional SEQ_AUTOREPEAT_EN
module motion_bus_master #(
  parameter int IDLE_GAP      = 1,
  parameter int REPEAT_PERIOD = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 ss_val,
  input  logic [15:0]                rv1,
  input  logic [15:0]                rv2,
  input  logic [15:0]                rh1,
  input  logic [15:0]                rh2,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 theta,
  output logic [1:0]                 phi,
  motion_bus_master_if.master        bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // GAP counts down from IDLE_GAP-1 to 0, so 0 marks its last cycle
  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_k;
  logic [3:0]  r_gap_cnt;
  logic [1:0]  r_ss;
  logic [15:0] r_rv1;
  logic [15:0] r_rv2;
  logic [15:0] r_rh1;
  logic [15:0] r_rh2;
  logic        w_launch;
  logic        w_repeat_fire;

`ifdef SEQ_AUTOREPEAT_EN
  localparam int RW = (REPEAT_PERIOD < 2) ? 1 : $clog2(REPEAT_PERIOD + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_active;

  // countdown is armed by DONE and fires on the last idle cycle of the period
  assign w_repeat_fire = r_rep_active && (r_rep_cnt == RW'(1));

  // repeat countdown: load in DONE, count idle cycles, drop on any launch
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rep_active <= 1'b0;
      r_rep_cnt    <= '0;
    end else if (r_state == S_DONE) begin
      r_rep_active <= 1'b1;
      r_rep_cnt    <= RW'(REPEAT_PERIOD);
    end else if (r_state == S_IDLE && r_rep_active) begin
      if (w_launch) begin
        r_rep_active <= 1'b0;
      end else begin
        r_rep_cnt <= r_rep_cnt - RW'(1);
      end
    end
  end
`else
  assign w_repeat_fire = 1'b0;
`endif

  // a new sequence can only begin from IDLE; DONE and busy states ignore start
  assign w_launch = (r_state == S_IDLE) && (start || w_repeat_fire);

  // state, transaction index, gap counter, snapshot and status capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_k       <= 3'd0;
      r_gap_cnt <= 4'd0;
      r_ss      <= 2'd0;
      r_rv1     <= 16'd0;
      r_rv2     <= 16'd0;
      r_rh1     <= 16'd0;
      r_rh2     <= 16'd0;
      theta     <= 2'd0;
      phi       <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_k   <= 3'd0;
        r_ss  <= ss_val;
        r_rv1 <= rv1;
        r_rv2 <= rv2;
        r_rh1 <= rh1;
        r_rh2 <= rh2;
      end
      if (r_state == S_ACCESS) begin
        if (r_k == 3'd5) begin
          theta <= bus.d_in[1:0];
        end
        if (r_k == 3'd6) begin
          phi <= bus.d_in[1:0];
        end
        r_gap_cnt <= GAP_LOAD;
      end else if (r_state == S_GAP) begin
        if (r_gap_cnt == 4'd0) begin
          r_k <= r_k + 3'd1;
        end else begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
        end
      end
    end
  end

  // next state and bus/status decode; the bus is quiet outside ACCESS
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    bus.cs    = 1'b0;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = 4'd0;
    bus.d_out = 16'd0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy     = 1'b1;
        bus.cs   = 1'b1;
        // transaction k lives at address 2*k (0x0..0xC)
        bus.addr = {r_k, 1'b0};
        case (r_k)
          3'd0: begin
            bus.wr    = 1'b1;
            bus.d_out = {14'd0, r_ss};
          end
          3'd1: begin
            bus.wr    = 1'b1;
            bus.d_out = r_rv1;
          end
          3'd2: begin
            bus.wr    = 1'b1;
            bus.d_out = r_rv2;
          end
          3'd3: begin
            bus.wr    = 1'b1;
            bus.d_out = r_rh1;
          end
          3'd4: begin
            bus.wr    = 1'b1;
            bus.d_out = r_rh2;
          end
          default: begin
            bus.rd = 1'b1;
          end
        endcase
        w_next = (r_k == 3'd6) ? S_DONE : S_GAP;
      end
      S_GAP: begin
        busy = 1'b1;
        if (r_gap_cnt == 4'd0) begin
          w_next = S_ACCESS;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_motion_bus_master.sv
// tb/tb_motion_bus_master.sv - randomized self-checking bench for motion_bus_master (gap 1 and gap 3 instances)
module tb_motion_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  ss_val = 2'd0;
  logic [15:0] rv1 = 16'd0;
  logic [15:0] rv2 = 16'd0;
  logic [15:0] rh1 = 16'd0;
  logic [15:0] rh2 = 16'd0;
  logic [15:0] per_a = 16'd3;
  logic [15:0] per_c = 16'd1;

  logic        busy1, done1, busy3, done3;
  logic [1:0]  theta1, phi1, theta3, phi3;

  logic [15:0] exp_w [0:4];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  motion_bus_master_if bus1 ();
  motion_bus_master_if bus3 ();

  // peripheral: status registers at 0xA/0xC, junk on d_in otherwise
  assign bus1.d_in = (bus1.cs && bus1.rd) ?
                     ((bus1.addr == 4'hA) ? per_a : (bus1.addr == 4'hC) ? per_c : 16'hDEAD) : 16'h5A5A;
  assign bus3.d_in = (bus3.cs && bus3.rd) ?
                     ((bus3.addr == 4'hA) ? per_a : (bus3.addr == 4'hC) ? per_c : 16'hDEAD) : 16'h5A5A;

  motion_bus_master #(.IDLE_GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .ss_val(ss_val),
    .rv1(rv1), .rv2(rv2), .rh1(rh1), .rh2(rh2),
    .busy(busy1), .done(done1), .theta(theta1), .phi(phi1), .bus(bus1)
  );

  motion_bus_master #(.IDLE_GAP(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .ss_val(ss_val),
    .rv1(rv1), .rv2(rv2), .rh1(rh1), .rh2(rh2),
    .busy(busy3), .done(done3), .theta(theta3), .phi(phi3), .bus(bus3)
  );

`ifdef SEQ_AUTOREPEAT_EN
  logic        busy_ar, done_ar;
  logic [1:0]  theta_ar, phi_ar;
  motion_bus_master_if bus_ar ();
  assign bus_ar.d_in = (bus_ar.cs && bus_ar.rd) ?
                       ((bus_ar.addr == 4'hA) ? per_a : (bus_ar.addr == 4'hC) ? per_c : 16'hDEAD) : 16'h5A5A;
  motion_bus_master #(.IDLE_GAP(1), .REPEAT_PERIOD(10)) u_dut_ar (
    .clk(clk), .rst(rst), .start(start), .ss_val(ss_val),
    .rv1(rv1), .rv2(rv2), .rh1(rh1), .rh2(rh2),
    .busy(busy_ar), .done(done_ar), .theta(theta_ar), .phi(phi_ar), .bus(bus_ar)
  );
`endif

  // observed outputs packed as {busy,done,cs,rd,wr,addr,d_out,theta,phi}
  function automatic logic [28:0] obs(input int d);
    if (d == 0)
      return {busy1, done1, bus1.cs, bus1.rd, bus1.wr, bus1.addr, bus1.d_out, theta1, phi1};
`ifdef SEQ_AUTOREPEAT_EN
    if (d == 2)
      return {busy_ar, done_ar, bus_ar.cs, bus_ar.rd, bus_ar.wr, bus_ar.addr, bus_ar.d_out, theta_ar, phi_ar};
`endif
    return {busy3, done3, bus3.cs, bus3.rd, bus3.wr, bus3.addr, bus3.d_out, theta3, phi3};
  endfunction

  // reference: expected outputs in cycle T+o from the timing rules; a reset
  // sampled at the edge after cycle T+r_off blanks everything afterwards
  function automatic logic [28:0] model(input int gap, input int o, input int r_off);
    int          p;
    int          k;
    logic        b, dn, cs, rd, wr;
    logic [3:0]  a;
    logic [15:0] dd;
    logic [1:0]  th, ph;
    p = 1 + gap;
    b = 0; dn = 0; cs = 0; rd = 0; wr = 0; a = 0; dd = 0; th = 0; ph = 0;
    if (o <= r_off) begin
      if (o >= 1 && o <= 1 + 6 * p) b = 1;
      if (o == 2 + 6 * p) dn = 1;
      if (o >= 1 && ((o - 1) % p) == 0 && ((o - 1) / p) <= 6) begin
        k  = (o - 1) / p;
        cs = 1;
        a  = 4'(2 * k);
        if (k < 5) begin
          wr = 1;
          dd = exp_w[k];
        end else begin
          rd = 1;
        end
      end
      if (o > 1 + 5 * p) th = per_a[1:0];
      if (o > 1 + 6 * p) ph = per_c[1:0];
    end
    return {b, dn, cs, rd, wr, a, dd, th, ph};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_inputs(input logic [1:0] s, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    ss_val = s; rv1 = a; rv2 = b; rh1 = c; rh2 = d;
    exp_w[0] = {14'd0, s}; exp_w[1] = a; exp_w[2] = b; exp_w[3] = c; exp_w[4] = d;
  endtask

  // start sampled at edge T; returns 1 time unit after that edge
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] got;
    start = 1'b1;
    set_inputs(2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got = obs(d);
      n_cmp++;
      if (got !== 29'd0) begin
        n_bad++;
        $display("FAIL reset_state dut=%0d got=%h exp=%h", d, got, 29'd0);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_sequence(input string name, input logic rnd);
    logic [28:0] got, exp;
    do_reset();
    if (rnd) begin
      per_a = 16'($urandom);
      per_c = 16'($urandom);
      set_inputs(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end else begin
      per_a = 16'h0003;
      per_c = 16'h0001;
      set_inputs(2'd2, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    end
    launch();
    for (int o = 1; o <= 30; o++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        got = obs(d);
        exp = model(d == 0 ? 1 : 3, o, 1000);
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL %s dut=%0d cycle=T+%0d got=%h exp=%h", name, d, o, got, exp);
        end
      end
    end
  endtask

  task automatic test_snapshot_and_ignore();
    logic [28:0] got, exp;
    do_reset();
    per_a = 16'($urandom);
    per_c = 16'($urandom);
    set_inputs(2'($urandom), 16'h1111, 16'($urandom), 16'($urandom), 16'($urandom));
    launch();
    for (int o = 1; o <= 32; o++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        got = obs(d);
        exp = model(d == 0 ? 1 : 3, o, 1000);
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL snapshot_ignore dut=%0d cycle=T+%0d got=%h exp=%h", d, o, got, exp);
        end
      end
      if (o == 2) rv1 = 16'hBEEF;
      if (o == 4 || o == 14) start = 1'b1;
      if (o == 5 || o == 15) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [28:0] got, exp;
    do_reset();
    per_a = 16'($urandom);
    per_c = 16'($urandom);
    set_inputs(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    launch();
    for (int o = 1; o <= 30; o++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        got = obs(d);
        exp = model(d == 0 ? 1 : 3, o, 6);
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL reset_mid dut=%0d cycle=T+%0d got=%h exp=%h", d, o, got, exp);
        end
      end
      if (o == 6) rst = 1'b0;
      if (o == 7) rst = 1'b1;
    end
    set_inputs(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    launch();
    for (int o = 1; o <= 30; o++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        got = obs(d);
        exp = model(d == 0 ? 1 : 3, o, 1000);
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL restart_after_reset dut=%0d cycle=T+%0d got=%h exp=%h", d, o, got, exp);
        end
      end
    end
  endtask

`ifdef SEQ_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic [28:0] got, exp;
    logic        full;
    do_reset();
    per_a = 16'($urandom);
    per_c = 16'($urandom);
    set_inputs(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    launch();
    for (int o = 1; o <= 56; o++) begin
      @(negedge clk);
      full = (o <= 24);
      if (o <= 24)      exp = model(1, o, 1000);
      else if (o <= 42) exp = model(1, o - 24, 1000);
      else              exp = model(1, o - 42, 1000);
      got = obs(2);
      n_cmp++;
      if (full ? (got !== exp) : (got[28:4] !== exp[28:4])) begin
        n_bad++;
        $display("FAIL autorepeat cycle=T+%0d got=%h exp=%h", o, got, exp);
      end
      if (o == 20)
        set_inputs(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if (o == 42) start = 1'b1;
      if (o == 43) start = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence("directed_seq", 1'b0);
    for (int i = 0; i < 3; i++) test_sequence("random_seq", 1'b1);
    test_snapshot_and_ignore();
    test_reset_mid();
`ifdef SEQ_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
